// File: rtl/psram_line_fetcher.sv
// Fetches one scanline per line-start pulse from PSRAM into a ping-pong line buffer.
// Latency: one read outstanding at a time; display read data is registered (1 cycle).
// Backpressure: strobes are held off while the controller is busy; a late line start restarts the fetch.
module psram_line_fetcher #(
    parameter int LINE_BYTES  = 320,
    parameter int LINE_STRIDE = 320,
    parameter int BUF_AW      = 9
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [23:0]       i_base_addr,
    input  logic              i_line_start,
    input  logic [8:0]        i_line_index,
    output logic              o_psram_stb,
    output logic              o_psram_we,
    output logic [23:0]       o_psram_addr,
    input  logic              i_psram_busy,
    input  logic              i_psram_done,
    input  logic [7:0]        i_psram_dout,
    input  logic [BUF_AW-1:0] i_rd_addr,
    output logic [7:0]        o_rd_data,
    output logic              o_fetching,
    output logic              o_underrun
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam int                DEPTH    = 2 ** BUF_AW;
    localparam logic [BUF_AW-1:0] CNT_LAST = BUF_AW'(LINE_BYTES - 1);
    localparam logic [BUF_AW-1:0] CNT_ONE  = BUF_AW'(1);
    localparam logic [BUF_AW:0]   RD_LIMIT = (BUF_AW + 1)'(LINE_BYTES);
    localparam logic [23:0]       STRIDE   = 24'(LINE_STRIDE);

    state_t            state_q, state_d;
    logic [23:0]       addr_q, addr_d;
    logic [BUF_AW-1:0] count_q, count_d;
    logic              pending_q, pending_d;
    logic              fill_bank_q;
    logic              buf_we;
    logic [23:0]       line_addr;
    logic [7:0]        line_buf [0:2*DEPTH-1];

    assign line_addr    = i_base_addr + 24'(i_line_index) * STRIDE;
    assign o_psram_we   = 1'b0;
    assign o_psram_addr = addr_q;
    assign o_fetching   = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        count_d     = count_q;
        pending_d   = pending_q;
        buf_we      = 1'b0;
        o_psram_stb = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_line_start) begin
                    addr_d  = line_addr;
                    count_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A restart in the same cycle suppresses the strobe so no stale read is left in flight.
                if (i_line_start) begin
                    addr_d  = line_addr;
                    count_d = '0;
                end else if (!i_psram_busy) begin
                    o_psram_stb = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (i_line_start) begin
                    addr_d  = line_addr;
                    count_d = '0;
                    if (i_psram_done) begin
                        pending_d = 1'b0;
                        state_d   = ISSUE;
                    end else begin
                        pending_d = 1'b1;
                    end
                end else if (i_psram_done) begin
                    if (pending_q) begin
                        pending_d = 1'b0;
                        count_d   = '0;
                        state_d   = ISSUE;
                    end else begin
                        buf_we  = 1'b1;
                        count_d = count_q + CNT_ONE;
                        addr_d  = addr_q + 24'd1;
                        state_d = (count_q == CNT_LAST) ? IDLE : ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            count_q     <= '0;
            pending_q   <= 1'b0;
            fill_bank_q <= 1'b0;
            o_underrun  <= 1'b0;
            o_rd_data   <= 8'h00;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            o_underrun <= i_line_start && (state_q != IDLE);
            if (i_line_start) begin
                fill_bank_q <= ~fill_bank_q;
            end
            o_rd_data <= ({1'b0, i_rd_addr} < RD_LIMIT) ? line_buf[{~fill_bank_q, i_rd_addr}] : 8'h00;
        end
    end

    always_ff @(posedge clk_i) begin
        if (buf_we) begin
            line_buf[{fill_bank_q, count_q}] <= i_psram_dout;
        end
    end
endmodule

// File: tb/tb_psram_line_fetcher.sv
// Directed bench for psram_line_fetcher with a fixed-latency PSRAM responder.
module tb_psram_line_fetcher;
    logic        clk_100mhz;
    logic        rstn_i;
    logic [23:0] i_base_addr;
    logic        i_line_start;
    logic [8:0]  i_line_index;
    logic        o_psram_stb;
    logic        o_psram_we;
    logic [23:0] o_psram_addr;
    logic        i_psram_busy;
    logic        i_psram_done;
    logic [7:0]  i_psram_dout;
    logic [8:0]  i_rd_addr;
    logic [7:0]  o_rd_data;
    logic        o_fetching;
    logic        o_underrun;

    psram_line_fetcher dut (
        .clk_i        (clk_100mhz),
        .rstn_i       (rstn_i),
        .i_base_addr  (i_base_addr),
        .i_line_start (i_line_start),
        .i_line_index (i_line_index),
        .o_psram_stb  (o_psram_stb),
        .o_psram_we   (o_psram_we),
        .o_psram_addr (o_psram_addr),
        .i_psram_busy (i_psram_busy),
        .i_psram_done (i_psram_done),
        .i_psram_dout (i_psram_dout),
        .i_rd_addr    (i_rd_addr),
        .o_rd_data    (o_rd_data),
        .o_fetching   (o_fetching),
        .o_underrun   (o_underrun)
    );

    int          err_cnt = 0;
    int          chk_cnt = 0;
    int          cyc = 0;
    int          dly = 0;
    int          first_stb_cyc = 0;
    int          last_done_cyc = 0;
    int          fall_cyc = 0;
    int          viol_busy = 0;
    int          viol_idle = 0;
    int          viol_outst = 0;
    int          underrun_cnt = 0;
    logic [23:0] resp_base = 24'h0;
    logic [23:0] log_addr[$];

    initial begin
        clk_100mhz = 1'b0;
        forever #5 clk_100mhz = ~clk_100mhz;
    end

    initial begin
        forever begin
            @(posedge clk_100mhz);
            cyc++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // PSRAM responder: done pulse 4 cycles after each strobe, data = byte index within the line.
    initial begin
        logic        stb_seen;
        logic [23:0] addr_seen;
        logic [23:0] pend_addr;
        logic [23:0] diff;
        i_psram_done = 1'b0;
        i_psram_dout = 8'h00;
        addr_seen    = '0;
        pend_addr    = '0;
        forever begin
            @(negedge clk_100mhz);
            stb_seen = 1'b0;
            if (rstn_i) begin
                if (o_underrun) underrun_cnt++;
                if (o_psram_stb) begin
                    stb_seen  = 1'b1;
                    addr_seen = o_psram_addr;
                    if (i_psram_busy) viol_busy++;
                    if (!o_fetching) viol_idle++;
                    if (dly > 0) viol_outst++;
                    if (log_addr.size() == 0) first_stb_cyc = cyc;
                    log_addr.push_back(o_psram_addr);
                end
            end
            @(posedge clk_100mhz);
            #1;
            i_psram_done = 1'b0;
            if (!rstn_i) begin
                dly = 0;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    i_psram_done  = 1'b1;
                    diff          = pend_addr - resp_base;
                    i_psram_dout  = diff[7:0];
                    last_done_cyc = cyc;
                end
            end
            if (stb_seen && rstn_i) begin
                dly       = 4;
                pend_addr = addr_seen;
            end
        end
    end

    task automatic pulse_start(input logic [8:0] idx);
        @(posedge clk_100mhz);
        #1;
        i_line_start = 1'b1;
        i_line_index = idx;
        @(posedge clk_100mhz);
        #1;
        i_line_start = 1'b0;
    endtask

    task automatic wait_fetch(input string tag);
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk_100mhz);
            if (!o_fetching) break;
        end
        fall_cyc = cyc;
        check_eq({tag, "_fetch_end"}, 32'(o_fetching), 32'd0);
    endtask

    task automatic wait_log(input string tag, input int n_stb);
        for (int n = 0; n < 4000; n++) begin
            if (log_addr.size() >= n_stb) break;
            @(negedge clk_100mhz);
        end
        check_eq({tag, "_reach"}, 32'(log_addr.size()), 32'(n_stb));
    endtask

    task automatic check_seq(input string tag, input logic [23:0] start, input int n_exp);
        int bad;
        bad = 0;
        check_eq({tag, "_stb_cnt"}, 32'(log_addr.size()), 32'(n_exp));
        for (int i = 0; i < log_addr.size(); i++) begin
            if (log_addr[i] !== start + 24'(i)) bad++;
        end
        check_eq({tag, "_addr_seq"}, 32'(bad), 32'd0);
    endtask

    task automatic rd_check(input string tag, input logic [8:0] a, input logic [7:0] exp);
        @(posedge clk_100mhz);
        #1;
        i_rd_addr = a;
        @(posedge clk_100mhz);
        @(negedge clk_100mhz);
        check_eq(tag, 32'(o_rd_data), 32'(exp));
    endtask

    initial begin
        int ur0;
        int rel_cyc;
        rstn_i       = 1'b0;
        i_base_addr  = 24'h0;
        i_line_start = 1'b0;
        i_line_index = 9'd0;
        i_psram_busy = 1'b0;
        i_rd_addr    = 9'd0;

        repeat (3) @(posedge clk_100mhz);
        @(negedge clk_100mhz);
        check_eq("rst_stb", 32'(o_psram_stb), 32'd0);
        check_eq("rst_we", 32'(o_psram_we), 32'd0);
        check_eq("rst_addr", 32'(o_psram_addr), 32'd0);
        check_eq("rst_rd_data", 32'(o_rd_data), 32'd0);
        check_eq("rst_fetching", 32'(o_fetching), 32'd0);
        check_eq("rst_underrun", 32'(o_underrun), 32'd0);
        @(posedge clk_100mhz);
        #1;
        rstn_i = 1'b1;

        // Basic fetch of line 2: 0x100 + 2*320 = 0x380.
        i_base_addr = 24'h000100;
        resp_base   = 24'h000380;
        log_addr.delete();
        pulse_start(9'd2);
        wait_fetch("t1");
        check_seq("t1", 24'h000380, 320);
        check_eq("t1_fall_latency", 32'(fall_cyc - last_done_cyc), 32'd1);
        check_eq("t1_no_underrun", 32'(underrun_cnt), 32'd0);

        // Busy gating on line 3 (0x4C0); line 2 becomes the display bank.
        log_addr.delete();
        resp_base = 24'h0004C0;
        @(posedge clk_100mhz);
        #1;
        i_psram_busy = 1'b1;
        pulse_start(9'd3);
        repeat (5) @(posedge clk_100mhz);
        #1;
        check_eq("t2_no_stb_while_busy", 32'(log_addr.size()), 32'd0);
        i_psram_busy = 1'b0;
        rel_cyc      = cyc;
        rd_check("t3_rd5", 9'd5, 8'h05);
        check_eq("t2_first_stb_cycle", 32'(first_stb_cyc), 32'(rel_cyc));
        rd_check("t3_rd255", 9'd255, 8'hFF);
        rd_check("t3_rd319", 9'd319, 8'h3F);
        rd_check("t3_rd320", 9'd320, 8'h00);
        rd_check("t3_rd511", 9'd511, 8'h00);
        wait_fetch("t2");
        check_seq("t2", 24'h0004C0, 320);

        // Underrun: line 4 (0x600) interrupted after byte 100's strobe by line 5 (0x740).
        log_addr.delete();
        resp_base = 24'h000600;
        ur0       = underrun_cnt;
        pulse_start(9'd4);
        wait_log("t4_byte100", 101);
        @(posedge clk_100mhz);
        #1;
        i_line_start = 1'b1;
        i_line_index = 9'd5;
        log_addr.delete();
        resp_base = 24'h000740;
        @(posedge clk_100mhz);
        #1;
        i_line_start = 1'b0;
        wait_fetch("t4");
        check_eq("t4_underrun_once", 32'(underrun_cnt - ur0), 32'd1);
        check_seq("t4", 24'h000740, 320);

        // Address wrap; line 5 is now the display bank.
        log_addr.delete();
        i_base_addr = 24'hFFFFF0;
        resp_base   = 24'hFFFFF0;
        pulse_start(9'd0);
        rd_check("t4_rd0", 9'd0, 8'h00);
        rd_check("t4_rd100", 9'd100, 8'h64);
        rd_check("t4_rd319", 9'd319, 8'h3F);
        wait_fetch("t5");
        check_seq("t5", 24'hFFFFF0, 320);
        if (log_addr.size() == 320) begin
            check_eq("t5_top", 32'(log_addr[15]), 32'h00FFFFFF);
            check_eq("t5_wrap", 32'(log_addr[16]), 32'h00000000);
            check_eq("t5_end", 32'(log_addr[319]), 32'h0000012F);
        end

        // Reset during WAIT on line 1 (0x240); wrap line is the display bank.
        log_addr.delete();
        i_base_addr = 24'h000100;
        resp_base   = 24'h000240;
        pulse_start(9'd1);
        rd_check("t6_rd7_pre", 9'd7, 8'h07);
        wait_log("t6_mid", 10);
        @(posedge clk_100mhz);
        #1;
        check_eq("t6_fetching_pre", 32'(o_fetching), 32'd1);
        rstn_i = 1'b0;
        #1;
        check_eq("t6_rst_stb", 32'(o_psram_stb), 32'd0);
        check_eq("t6_rst_fetching", 32'(o_fetching), 32'd0);
        check_eq("t6_rst_underrun", 32'(o_underrun), 32'd0);
        check_eq("t6_rst_rd_data", 32'(o_rd_data), 32'd0);
        repeat (3) @(posedge clk_100mhz);
        #1;
        rstn_i = 1'b1;
        log_addr.delete();
        resp_base = 24'h000380;
        pulse_start(9'd2);
        wait_fetch("t6");
        check_seq("t6", 24'h000380, 320);

        check_eq("stb_while_busy", 32'(viol_busy), 32'd0);
        check_eq("stb_while_idle", 32'(viol_idle), 32'd0);
        check_eq("multi_outstanding", 32'(viol_outst), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
